// File: rtl/led_level_ctrl.sv
// led_level_ctrl: two-button up/down level counter for an LED bar graph.
// Raw buttons are synchronized and debounced, then a small FSM turns presses
// into single steps with hold-to-repeat. The saturating 5-bit count and its
// min/max flags are registered together.
module led_level_ctrl #(
  parameter int unsigned DEBOUNCE_CYC    = 1000000,
  parameter int unsigned REPEAT_DLY_CYC  = 50000000,
  parameter int unsigned REPEAT_RATE_CYC = 10000000,
  parameter int unsigned MAX_CNT         = 18
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btnUp,
  input  logic       i_btnDown,
  input  logic       i_clear,
  output logic [4:0] o_LEDcnt,
  output logic       o_atMax,
  output logic       o_atMin
);

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TMR_MAX = (REPEAT_DLY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DLY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(REPEAT_DLY_CYC - 1);
  localparam logic [TMR_W-1:0] RATE_LAST = TMR_W'(REPEAT_RATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CNT);

  // Bit 0 carries the up button, bit 1 the down button throughout.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD_UP = 3'd1,
    RPT_UP  = 3'd2,
    HOLD_DN = 3'd3,
    RPT_DN  = 3'd4,
    LOCK    = 3'd5
  } state_e;

  logic [1:0]       meta_q;
  logic [1:0]       sync_q;
  logic [DB_W-1:0]  db_cnt_q [2];
  logic [1:0]       db_q;
  logic [1:0]       db_prev_q;

  state_e           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             step_up_q;
  logic             step_dn_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max_q;
  logic             at_min_q;

  logic             up_lvl;
  logic             dn_lvl;
  logic             up_rise;
  logic             dn_rise;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {i_btnDown, i_btnUp};
      sync_q <= meta_q;
    end
  end

  // Per-button debouncer: the counter only runs while the synchronized level
  // disagrees with the debounced level, so any toggle restarts it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
    end else begin
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_q[i]     <= sync_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign up_lvl  = db_q[0];
  assign dn_lvl  = db_q[1];
  assign up_rise = db_q[0] & ~db_prev_q[0];
  assign dn_rise = db_q[1] & ~db_prev_q[1];

  // Press / hold / repeat FSM; steps are one-cycle registered pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
    end else begin
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      if (up_lvl && dn_lvl) begin
        state_q <= LOCK;
        tmr_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            tmr_q <= '0;
            if (up_rise && !dn_lvl) begin
              step_up_q <= 1'b1;
              state_q   <= HOLD_UP;
            end else if (dn_rise && !up_lvl) begin
              step_dn_q <= 1'b1;
              state_q   <= HOLD_DN;
            end
          end
          HOLD_UP: begin
            if (!up_lvl) begin
              state_q <= IDLE;
              tmr_q   <= '0;
            end else if (tmr_q == DLY_LAST) begin
              step_up_q <= 1'b1;
              state_q   <= RPT_UP;
              tmr_q     <= '0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          RPT_UP: begin
            if (!up_lvl) begin
              state_q <= IDLE;
              tmr_q   <= '0;
            end else if (tmr_q == RATE_LAST) begin
              step_up_q <= 1'b1;
              tmr_q     <= '0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          HOLD_DN: begin
            if (!dn_lvl) begin
              state_q <= IDLE;
              tmr_q   <= '0;
            end else if (tmr_q == DLY_LAST) begin
              step_dn_q <= 1'b1;
              state_q   <= RPT_DN;
              tmr_q     <= '0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          RPT_DN: begin
            if (!dn_lvl) begin
              state_q <= IDLE;
              tmr_q   <= '0;
            end else if (tmr_q == RATE_LAST) begin
              step_dn_q <= 1'b1;
              tmr_q     <= '0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          LOCK: begin
            tmr_q <= '0;
            if (!up_lvl && !dn_lvl) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            tmr_q   <= '0;
          end
        endcase
      end
    end
  end

  // Next count: clear wins over steps, steps saturate at 0 and CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (step_up_q && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (step_dn_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count and flags registered from the same next value so they never disagree.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q    <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      at_max_q <= (cnt_d == CNT_MAX);
      at_min_q <= (cnt_d == '0);
    end
  end

  assign o_LEDcnt = cnt_q;
  assign o_atMax  = at_max_q;
  assign o_atMin  = at_min_q;

endmodule

// File: tb/tb_led_level_ctrl.sv
// Directed bench for led_level_ctrl with short debounce/repeat timing.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_led_level_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_dn;
  logic       clr;
  logic [4:0] led_cnt;
  logic       at_max;
  logic       at_min;

  int errors;
  int checks;

  led_level_ctrl #(
    .DEBOUNCE_CYC   (4),
    .REPEAT_DLY_CYC (20),
    .REPEAT_RATE_CYC(5),
    .MAX_CNT        (18)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_btnUp  (btn_up),
    .i_btnDown(btn_dn),
    .i_clear  (clr),
    .o_LEDcnt (led_cnt),
    .o_atMax  (at_max),
    .o_atMin  (at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    clr    = 1'b0;
    rst    = 1'b1;
    ticks(2);
    rst    = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    clr    = 1'b0;
    rst    = 1'b1;

    // Reset state
    ticks(2);
    check("rst_cnt", int'(led_cnt), 0);
    check("rst_atmin", int'(at_min), 1);
    check("rst_atmax", int'(at_max), 0);
    rst = 1'b0;
    ticks(3);

    // Clean press: 2 sync + 4 debounce + 1 FSM + 1 count = 8 cycles latency
    btn_up = 1'b1;
    ticks(7);
    check("press_pre_cnt", int'(led_cnt), 0);
    check("press_pre_atmin", int'(at_min), 1);
    tick();
    check("press_cnt", int'(led_cnt), 1);
    check("press_atmin", int'(at_min), 0);
    ticks(2);
    btn_up = 1'b0;
    ticks(15);
    check("press_once", int'(led_cnt), 1);

    // Bounce: 3-cycle pulses never reach the 4-cycle debounce
    do_reset();
    for (int p = 0; p < 5; p++) begin
      btn_up = 1'b1;
      ticks(3);
      btn_up = 1'b0;
      ticks(3);
    end
    ticks(10);
    check("bounce_cnt", int'(led_cnt), 0);
    check("bounce_atmin", int'(at_min), 1);

    // Auto-repeat: steps land at 8, 28, then every 5; release after 60
    do_reset();
    btn_up = 1'b1;
    for (int t = 1; t <= 90; t++) begin
      tick();
      case (t)
        7:  check("rpt_t7", int'(led_cnt), 0);
        8:  check("rpt_t8", int'(led_cnt), 1);
        27: check("rpt_t27", int'(led_cnt), 1);
        28: check("rpt_t28", int'(led_cnt), 2);
        32: check("rpt_t32", int'(led_cnt), 2);
        33: check("rpt_t33", int'(led_cnt), 3);
        62: check("rpt_t62", int'(led_cnt), 8);
        63: check("rpt_t63", int'(led_cnt), 9);
        90: check("rpt_final", int'(led_cnt), 9);
        default: ;
      endcase
      if (t == 60) btn_up = 1'b0;
    end

    // Saturation up: 17 at t=103, 18 at t=108, then stays
    do_reset();
    btn_up = 1'b1;
    for (int t = 1; t <= 130; t++) begin
      tick();
      case (t)
        103: begin
          check("sat_up_17", int'(led_cnt), 17);
          check("sat_up_17_atmax", int'(at_max), 0);
        end
        108: begin
          check("sat_up_18", int'(led_cnt), 18);
          check("sat_up_18_atmax", int'(at_max), 1);
        end
        130: check("sat_up_hold", int'(led_cnt), 18);
        default: ;
      endcase
    end
    btn_up = 1'b0;
    ticks(20);
    check("sat_up_rel", int'(led_cnt), 18);
    check("sat_up_rel_atmax", int'(at_max), 1);

    // Saturation down from 18: 1 at t=103, 0 at t=108, then stays
    btn_dn = 1'b1;
    for (int t = 1; t <= 130; t++) begin
      tick();
      case (t)
        8:   check("sat_dn_first", int'(led_cnt), 17);
        103: check("sat_dn_1", int'(led_cnt), 1);
        108: begin
          check("sat_dn_0", int'(led_cnt), 0);
          check("sat_dn_0_atmin", int'(at_min), 1);
        end
        130: check("sat_dn_hold", int'(led_cnt), 0);
        default: ;
      endcase
    end
    btn_dn = 1'b0;
    ticks(20);
    check("sat_dn_rel", int'(led_cnt), 0);

    // Conflict: both held gives no step; LOCK releases cleanly afterwards
    do_reset();
    btn_up = 1'b1;
    ticks(10);
    btn_up = 1'b0;
    ticks(15);
    check("lock_pre", int'(led_cnt), 1);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 8)  check("lock_t8", int'(led_cnt), 1);
      if (t == 40) check("lock_t40", int'(led_cnt), 1);
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    ticks(15);
    check("lock_rel", int'(led_cnt), 1);
    btn_up = 1'b1;
    ticks(8);
    check("lock_exit_press", int'(led_cnt), 2);
    btn_up = 1'b0;
    ticks(15);

    // Clear at count 9 coinciding with the step issued at t=67
    do_reset();
    btn_up = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      case (t)
        63: check("clr_t63", int'(led_cnt), 9);
        67: check("clr_t67", int'(led_cnt), 9);
        68: begin
          check("clr_t68", int'(led_cnt), 0);
          check("clr_t68_atmin", int'(at_min), 1);
        end
        72: check("clr_t72", int'(led_cnt), 0);
        73: check("clr_t73_timer_kept", int'(led_cnt), 1);
        default: ;
      endcase
      if (t == 67) clr = 1'b1;
      if (t == 68) clr = 1'b0;
    end
    btn_up = 1'b0;
    ticks(15);

    // Reset mid-repeat at count 7; held button re-debounces as a fresh press
    do_reset();
    btn_up = 1'b1;
    for (int t = 1; t <= 55; t++) begin
      tick();
      if (t == 53) check("mrst_t53", int'(led_cnt), 7);
      if (t == 55) check("mrst_t55", int'(led_cnt), 7);
    end
    rst = 1'b1;
    tick();
    check("mrst_cnt", int'(led_cnt), 0);
    check("mrst_atmin", int'(at_min), 1);
    rst = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      tick();
      if (r == 7) check("mrst_r7", int'(led_cnt), 0);
      if (r == 8) check("mrst_r8", int'(led_cnt), 1);
    end
    btn_up = 1'b0;
    ticks(15);
    check("mrst_final", int'(led_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
